mux16_rr_sched: RTL
===================

# mux16_rr_sched

Round-robin scheduler that shares the 16:1 bit-select mux among 16 requesters. It watches a 16-bit request vector, grants one requester at a time, and drives the mux `sel` with the winner's index. A per-grant hold counter caps how long one requester can own the mux. Fully synchronous; sits directly in front of the 16:1 mux, with `sel` wired straight to the mux select.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant lasts. Legal range 1..255.
- `HOLD_W`, default 8: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  16: level requests; bit i = requester i wants the mux.
- `gnt`  out  16: one-hot grant, registered; all-zero when idle.
- `gnt_valid`  out  1: high exactly when `gnt` is non-zero.
- `sel`  out  4: index of current owner, registered; drives the mux select.

## Operation

- State: `IDLE` or `GRANT`. Registers are the owner index, the round-robin pointer `ptr` (4 bits), and the hold count `cnt` (`HOLD_W` bits).
- Search order: the winner is the first set bit of the candidate vector, scanning `ptr`, `ptr+1`, … mod 16.
- On every new grant: `ptr <= winner + 1` mod 16, and `cnt <= 1`.
- `IDLE`:
  - `req == 0`: stay in `IDLE`.
  - Otherwise: pick the winner, go to `GRANT`, and assert `gnt[winner]`, `sel = winner`, `gnt_valid = 1`.
- `GRANT`, owner `o`:
  - `req[o]` high and `cnt < MAX_HOLD`: keep the grant; `cnt <= cnt + 1`.
  - Release (`req[o]` low) or expiry (`req[o]` high and `cnt == MAX_HOLD`): re-arbitrate the same cycle over the current `req`, scanning from `ptr` (= o+1).
    - On release, `o` is not a candidate.
    - On expiry, `o` is a candidate but has lowest priority. If `o` is the only requester, it is re-granted and `cnt <= 1`; `gnt` and `sel` stay unchanged.
  - No candidate: go to `IDLE`; `gnt = 0`, `gnt_valid = 0`.
- `sel` holds its last value while idle, so the mux output stays stable. `sel` changes only on a new grant.
- Non-owner requests may rise or fall at any time. A request withdrawn before it is granted leaves no state behind.
- Owner handover has no bubble.

## Timing

- Reset values: `gnt = 0`, `gnt_valid = 0`, `sel = 0`, `ptr = 0`, `cnt = 0`, state `IDLE`.
- `rst` sampled high at edge k: all registers hold reset values after edge k, regardless of `req`.
- Reset mid-grant: the grant drops on the next edge. The first grant after reset scans from index 0.
- Request latency: `req` rises before edge t while idle → `gnt` and `sel` are valid after edge t (1 cycle).
- Release: `req[o]` low before edge t → after edge t, `gnt` shows the next winner or zero.
- Maximum continuous ownership is `MAX_HOLD` cycles while others are waiting. With `MAX_HOLD = 1`, ownership rotates every cycle.
- Starvation bound: a steadily asserted requester is granted within 15·`MAX_HOLD` + 1 cycles.
- Wrap-around: the scan wraps 15→0. A `ptr` of 0 after owner 15 is the normal case.
- Invariant: `gnt` is one-hot or zero in every cycle, and `gnt == (1 << sel)` whenever `gnt_valid` is high.

## Structure

- Shared package `mux_sched_pkg` holds:
  - `NUM_REQ = 16` and `SEL_W = 4`;
  - state encodings `ST_IDLE = 1'b0`, `ST_GRANT = 1'b1`.
- One sub-module, `rr_pick16`: purely combinational.
  - Inputs: `cand[15:0]`, `ptr[3:0]`.
  - Outputs: `found`, `idx[3:0]`.
  - Function: first set bit at or after `ptr`, wrapping. It is instantiated once.
- The top level holds the state register, counter, pointer, and output registers.
- On expiry, the candidate mask for `rr_pick16` is formed externally, so the owner gets lowest priority automatically because `ptr = o+1`.

## Test plan

- **Reset:** `rst` high for 2 cycles with `req = 16'hFFFF` → `gnt = 0`, `sel = 0`, `gnt_valid = 0` throughout. One cycle after `rst` falls, `gnt = 16'h0001`, `sel = 0`.
- **Single holder:** `req = 16'h0020` held, `MAX_HOLD = 8` → `gnt = 16'h0020`, `sel = 5` from the next cycle. The grant stays continuous across expiry, with `cnt` reloading every 8 cycles.
- **Full contention:** `req = 16'hFFFF`, `MAX_HOLD = 4` → `sel` steps 0,1,…,15,0, each value held exactly 4 cycles, with no idle cycles.
- **Release handover:** owner 3 drops `req[3]` at cycle t while `req[9]` is high → at t+1, `gnt = 16'h0200`, `sel = 9`, `gnt_valid` stays high.
- **Wrap and skip:** owner 15 expires with `req = 16'hC004` (bits 2, 14, 15) → next `sel = 2`, then 14, then 15.
- **Reset mid-grant and idle:**
  - Assert `rst` while owner 7 is granted → next cycle all outputs are zero.
  - Separately, drop all requests → `gnt_valid = 0` and `sel` retains its last index.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// rtl/mux_sched_pkg.sv - shared constants and state encoding for the 16-way mux scheduler
package mux_sched_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick16.sv
// rtl/rr_pick16.sv - combinational round-robin picker: first set bit at or after ptr, wrapping
module rr_pick16
    import mux_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] cand,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] pos;

    // 4-bit addition wraps 15 -> 0 on its own
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = ptr + SEL_W'(i);
            if (!found && cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_sched.sv
// rtl/mux16_rr_sched.sv - round-robin owner of a 16:1 mux with a per-grant hold limit
module mux16_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [SEL_W-1:0]   sel
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt, sel_nxt, win;
    logic [HOLD_W-1:0]  cnt, cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, cand;
    logic               valid_nxt, found, keep;

    // Owner's own request stays in the mask: on release it is already low, and on
    // expiry ptr = owner+1 places it last in the scan.
    assign cand = req;
    assign keep = (state == ST_GRANT) && req[sel] && (cnt < HOLD_MAX);

    rr_pick16 u_pick (
        .cand  (cand),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        valid_nxt = gnt_valid;
        if (keep) begin
            cnt_nxt = cnt + HOLD_W'(1);
        end else if (found) begin
            state_nxt = ST_GRANT;
            ptr_nxt   = win + SEL_W'(1);
            cnt_nxt   = HOLD_W'(1);
            sel_nxt   = win;
            gnt_nxt   = NUM_REQ'(1) << win;
            valid_nxt = 1'b1;
        end else begin
            // sel deliberately left alone so the mux output stays stable while idle
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            sel       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            sel       <= sel_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= valid_nxt;
        end
    end

endmodule
